sync_to_async_tx: RTL and testbench
===================================

Name: sync_to_async_tx

Overview:
- Clocked-to-asynchronous bridge feeding the first Muller C element stage of the micropipeline.
- Accepts words from the synchronous domain over a valid/ready interface and buffers them in a small FIFO.
- Issues each word as a 4-phase (return-to-zero) bundled-data transaction using req_out/data_out/ack_in.
- ack_in comes from the asynchronous stage and is synchronised internally before use.

Parameters:
- DATA_W, 8, width of data words.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- SYNC_STAGES, 2, flip-flop stages on ack_in; must be at least 2.
- SETUP_CYCLES, 1, clock cycles data_out is held stable before req_out rises (bundled-data margin); must be at least 1.
- TIMEOUT_CYCLES, 255, handshake watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_W  word from the synchronous producer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a word.
- data_out  output  DATA_W  bundled data to the async pipeline.
- req_out  output  1  4-phase request to the async pipeline.
- ack_in  input  1  4-phase acknowledge from the async pipeline; asynchronous to clk.
- busy  output  1  a handshake is in progress or the FIFO is non-empty.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- timeout_err  output  1  present only with ACK_TIMEOUT_EN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - req_out=0, data_out=0, fifo_count=0, busy=0, in_ready=1.
  - FSM in IDLE.
  - Synchroniser flops cleared to 0.
  - timeout_err=0.
- ack_s is ack_in after SYNC_STAGES flops. It is the only version of the acknowledge used internally.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address, so full and empty are distinguishable.
  - in_ready = !full, combinational from registered state.
  - Push when in_valid && in_ready.
  - Pop only in IDLE under the conditions below.
  - Push and pop in the same cycle: count unchanged, both pointers advance and wrap modulo FIFO_DEPTH.
  - Push when full cannot occur (in_ready=0).
  - A word pushed into an empty FIFO is poppable on the following cycle, never the same cycle.
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO.
  - IDLE: if FIFO non-empty and ack_s==0, pop the head word into data_out and go to SETUP with setup counter=0. Otherwise stay.
  - SETUP: counter increments each cycle. When it reaches SETUP_CYCLES-1, assert req_out and go to REQ_HI. data_out is held.
  - REQ_HI: req_out=1, data_out held. When ack_s==1, deassert req_out and go to REQ_LO.
  - REQ_LO: req_out=0, data_out held. When ack_s==0, go to IDLE.
- data_out changes only on a pop. It holds its last value at all other times.
- Latency from a push into an empty FIFO at edge t:
  - pop/data_out valid at t+2;
  - req_out high at t+2+SETUP_CYCLES.
- Throughput: at most one word per full 4-phase cycle. The minimum cycle is bounded by 2×SYNC_STAGES plus the async stage delay.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-handshake: req_out drops to 0 immediately on the reset edge and the FIFO is flushed.
  - If ack_in is still high, IDLE blocks new transactions until ack_s==0.
  - No request is issued on top of a stale acknowledge.
- ack_s toggling outside the state expecting it (e.g. rising in SETUP) is ignored until the matching state.

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to REQ_HI and on entry to REQ_LO, and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set. It is sticky until rst.
  - The FSM keeps waiting; there is no abort.
- Not defined: no counter, no timeout_err port.

Test Plan:
- Single word: push 8'hA5 into the empty FIFO with SETUP_CYCLES=1 and an ack model with a 3-cycle delay -> data_out=A5 two cycles after the push; req_out rises one cycle later; req falls after ack_s=1; IDLE after ack_s=0; busy drops to 0.
- FIFO full: hold ack_in=0 and push 5 words (01..05), DEPTH=4 -> first word popped into data_out, so 01..05 all accepted; next push stalls with in_ready=0 and fifo_count=4. Release ack -> words emerge in order 01..05.
- Simultaneous push/pop: push while IDLE pops with count=2 -> fifo_count stays 2; pointers wrap correctly across 3 FIFO passes (12 words, order preserved).
- Reset mid-handshake: assert rst in REQ_HI with ack_in=1 -> req_out=0 and fifo_count=0 next cycle; a new word pushed is not requested until ack_in has been low for SYNC_STAGES cycles.
- Setup margin: SETUP_CYCLES=3 -> req_out rises exactly 3 cycles after data_out updates; data_out is stable through REQ_LO.
- Timeout (ACK_TIMEOUT_EN, TIMEOUT_CYCLES=10): ack_in stuck at 0 -> timeout_err=1 after 10 cycles in REQ_HI. A late ack then completes normally and timeout_err stays 1 until rst.

Source files
------------

// File: rtl/sync_to_async_tx.sv
// Synchronous valid/ready to 4-phase bundled-data bridge with a small FIFO and an ack_in synchroniser.
// Optional ack watchdog (timeout_err port) is compiled in when ACK_TIMEOUT_EN is defined.
module sync_to_async_tx #(
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             data_out,
    output logic                          req_out,
    input  logic                          ack_in,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef ACK_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [PW-1:0] FULL_CNT   = PW'(FIFO_DEPTH);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("SETUP_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

    state_t                   state_q, state_d;
    logic                     req_d, pop, push, full, empty;
    logic [SW-1:0]            setup_cnt, cnt_d;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [DATA_W-1:0]        mem [FIFO_DEPTH];
    logic [SYNC_STAGES-1:0]   ack_sync, sync_vld;
    logic                     ack_s, ack_clear;

    // sync_vld fills behind reset so the cleared synchroniser is not mistaken
    // for a low acknowledge while a stale ack_in is still high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
            sync_vld <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign ack_clear = sync_vld[SYNC_STAGES-1] && !ack_s;

    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = (fifo_count == FULL_CNT);
    assign empty      = (wr_ptr == rd_ptr);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign busy       = (state_q != IDLE) || (fifo_count != '0);

    always_comb begin
        state_d = state_q;
        req_d   = req_out;
        cnt_d   = setup_cnt;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty && ack_clear) begin
                pop     = 1'b1;
                cnt_d   = '0;
                state_d = SETUP;
            end
            SETUP: if (setup_cnt == SETUP_LAST) begin
                req_d   = 1'b1;
                state_d = REQ_HI;
            end else begin
                cnt_d = setup_cnt + SW'(1);
            end
            REQ_HI: if (ack_s) begin
                req_d   = 1'b0;
                state_d = REQ_LO;
            end
            REQ_LO: if (!ack_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_out   <= 1'b0;
            data_out  <= '0;
            setup_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state_q   <= state_d;
            req_out   <= req_d;
            setup_cnt <= cnt_d;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                data_out <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

`ifdef ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_entry, wd_active;

    assign wd_entry  = (state_d != state_q) && (state_d == REQ_HI || state_d == REQ_LO);
    assign wd_active = (state_q == REQ_HI) || (state_q == REQ_LO);

    // Error latches on the same edge the count reaches the limit; the FSM keeps waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (wd_entry) begin
            wd_cnt <= '0;
        end else if (wd_active) begin
            if (wd_cnt != TW'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + TW'(1);
            if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_to_async_tx.sv
// Directed/randomised bench: queue scoreboard for word order, occupancy model, handshake timing.
module tb_sync_to_async_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_out;
    logic       req_out;
    logic       ack_in = 1'b0;
    logic       busy;
    logic [2:0] fifo_count;
    logic       timeout_err;

    logic [7:0] b_in_data;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_data_out;
    logic       b_req_out;
    logic       b_ack_in = 1'b0;
    logic       b_busy;
    logic [2:0] b_fifo_count;
    logic       b_timeout_err;

    always #5 clk = ~clk;

    sync_to_async_tx #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .SETUP_CYCLES(1),
                       .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .req_out(req_out), .ack_in(ack_in), .busy(busy),
        .fifo_count(fifo_count)
`ifdef ACK_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    sync_to_async_tx #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .SETUP_CYCLES(3),
                       .TIMEOUT_CYCLES(10)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_out(b_data_out), .req_out(b_req_out), .ack_in(b_ack_in), .busy(b_busy),
        .fifo_count(b_fifo_count)
`ifdef ACK_TIMEOUT_EN
        , .timeout_err(b_timeout_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Async stage models: ack follows req after a fixed number of cycles unless forced.
    int ack_mode = 0;  // 0 follow req, 1 stuck low, 2 stuck high
    int dly_a = 0;
    int dly_b = 0;
    always @(negedge clk) begin
        if (ack_mode == 1) ack_in <= 1'b0;
        else if (ack_mode == 2) ack_in <= 1'b1;
        else if (req_out != ack_in) begin
            if (dly_a >= 2) begin ack_in <= req_out; dly_a <= 0; end
            else dly_a <= dly_a + 1;
        end else dly_a <= 0;
    end
    always @(negedge clk) begin
        if (b_req_out != b_ack_in) begin
            if (dly_b >= 1) begin b_ack_in <= b_req_out; dly_b <= 0; end
            else dly_b <= dly_b + 1;
        end else dly_b <= 0;
    end

    // Scoreboard: every request must carry the oldest accepted word and hold it
    // until the acknowledge returns low. Occupancy follows pushes minus pops, a pop
    // being visible as the req_out rise one edge later (SETUP_CYCLES=1).
    logic [7:0] exp_q[$];
    logic [7:0] last_w = '0;
    logic req_p = 1'b0, ack_p = 1'b0, in_hs = 1'b0;
    int hist = 0, c1 = 0, c2 = 0, wp1 = 0, wp2 = 0;
    int rx_cnt = 0, tx_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            hist  = 0;
            in_hs = 1'b0;
        end else begin
            if (req_out && !req_p) begin
                chk("sb_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    last_w = exp_q.pop_front();
                    chk("sb_order", data_out, last_w);
                    rx_cnt++;
                    in_hs = 1'b1;
                end
            end
            if (in_hs && !req_out && req_p) chk("sb_hold_reqfall", data_out, last_w);
            if (in_hs && !req_out && !ack_in && ack_p) begin
                chk("sb_hold_ackfall", data_out, last_w);
                in_hs = 1'b0;
            end
            if (hist >= 2) chk("cnt_model", c1, c2 + wp2 - int'(req_out && !req_p));
            c2  = c1;
            c1  = int'(fifo_count);
            wp2 = wp1;
            wp1 = int'(in_valid && in_ready);
            if (hist < 2) hist++;
        end
        req_p = req_out;
        ack_p = ack_in;
    end

    task automatic push(input logic [7:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("push_stall_bound", n < 200, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(w);
        tx_cnt++;
    endtask

    task automatic wait_req_high(input string tag);
        int n = 0;
        while (req_out !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk(tag, n < 200, 1'b1);
    endtask

    task automatic poll_ack(input logic v, input string tag);
        int n = 0;
        while (ack_in !== v && n < 2000) begin #1; n++; end
        chk(tag, n < 2000, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || req_out || ack_in) && n < 400) begin @(negedge clk); n++; end
        chk(tag, n < 400, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] w;
        int n, m;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; b_in_valid = 1'b0; b_in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req_out, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_b_req", b_req_out, 1'b0);
        chk("rst_b_count", b_fifo_count, 3'd0);
`ifdef ACK_TIMEOUT_EN
        chk("rst_timeout", timeout_err, 1'b0);
`endif
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Single word: data_out two edges after the drive edge, req one edge later.
        in_data = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        exp_q.push_back(8'hA5); tx_cnt++;
        @(negedge clk);
        chk("t1_count_after_push", fifo_count, 3'd1);
        chk("t1_data_before_pop", data_out, 8'h00);
        @(negedge clk);
        chk("t1_data_popped", data_out, 8'hA5);
        chk("t1_req_not_yet", req_out, 1'b0);
        chk("t1_count_after_pop", fifo_count, 3'd0);
        @(negedge clk);
        chk("t1_req_rise", req_out, 1'b1);
        wait_idle("t1_idle_bound");
        chk("t1_busy_low", busy, 1'b0);
        chk("t1_rx", rx_cnt, 1);

        // FIFO full with ack held low.
        ack_mode = 1;
        for (int i = 1; i <= 5; i++) push(8'(i));
        @(negedge clk);
        chk("t2_count_full", fifo_count, 3'd4);
        chk("t2_in_ready_low", in_ready, 1'b0);
        chk("t2_req_first", req_out, 1'b1);
        chk("t2_data_first", data_out, 8'h01);
        in_data = 8'h06; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_ready", in_ready, 1'b0);
            chk("t2_stall_count", fifo_count, 3'd4);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        ack_mode = 0;
        wait_idle("t2_idle_bound");
        chk("t2_rx", rx_cnt, tx_cnt);

        // Push coinciding with an IDLE pop at occupancy 2, then a wrapping random stream.
        ack_mode = 1;
        push(8'($urandom));
        wait_req_high("t3_req_bound");
        push(8'($urandom));
        w = exp_q[0];
        push(8'($urandom));
        @(negedge clk);
        chk("t3_count_two", fifo_count, 3'd2);
        ack_mode = 0;
        poll_ack(1'b1, "t3_ack_rise_bound");
        poll_ack(1'b0, "t3_ack_fall_bound");
        // ack_s low after two edges, REQ_LO->IDLE on the third, pop on the fourth.
        repeat (3) @(posedge clk);
        #1 in_data = 8'($urandom); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        exp_q.push_back(in_data); tx_cnt++;
        @(negedge clk);
        chk("t3_pushpop_count", fifo_count, 3'd2);
        chk("t3_pushpop_data", data_out, w);
        for (int i = 0; i < 12; i++) push(8'($urandom));
        wait_idle("t3_idle_bound");
        chk("t3_rx", rx_cnt, tx_cnt);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Reset in REQ_HI with ack_in high; stale ack must block the next request.
        ack_mode = 1;
        push(8'h3C);
        wait_req_high("t4_req_bound");
        push(8'h11);
        push(8'h22);
        @(posedge clk); #1 ack_mode = 2; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_req_dropped", req_out, 1'b0);
        chk("t4_flushed", fifo_count, 3'd0);
        chk("t4_data_cleared", data_out, 8'h00);
        exp_q.delete();
        tx_cnt = rx_cnt;
        @(posedge clk); #1 rst = 1'b0;
        push(8'h5A);
        repeat (8) begin
            @(negedge clk);
            chk("t4_stale_req", req_out, 1'b0);
            chk("t4_stale_data", data_out, 8'h00);
        end
        chk("t4_word_waiting", fifo_count, 3'd1);
        ack_mode = 0;
        poll_ack(1'b0, "t4_ack_fall_bound");
        repeat (2) begin
            @(negedge clk);
            chk("t4_sync_wait", req_out, 1'b0);
        end
        wait_idle("t4_idle_bound");
        chk("t4_rx", rx_cnt, tx_cnt);

        // Setup margin on the SETUP_CYCLES=3 instance.
        w = 8'($urandom_range(1, 255));
        b_in_data = w; b_in_valid = 1'b1;
        @(posedge clk); #1 b_in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (b_data_out !== w && n < 20);
        chk("t5_pop_latency", n, 2);
        m = 0;
        while (!b_req_out && m < 20) begin @(negedge clk); m++; end
        chk("t5_setup_cycles", m, 3);
        n = 0;
        while (b_req_out && n < 50) begin
            chk("t5_hold_req_hi", b_data_out, w);
            @(negedge clk); n++;
        end
        n = 0;
        while (b_ack_in && n < 50) begin
            chk("t5_hold_req_lo", b_data_out, w);
            @(negedge clk); n++;
        end
        n = 0;
        while (b_busy && n < 50) begin @(negedge clk); n++; end
        chk("t5_idle_bound", n < 50, 1'b1);
        chk("t5_data_held", b_data_out, w);

`ifdef ACK_TIMEOUT_EN
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_err_cleared", timeout_err, 1'b0);
        tx_cnt = rx_cnt;
        ack_mode = 1;
        push(8'hC3);
        wait_req_high("t6_req_bound");
        repeat (8) @(negedge clk);
        chk("t6_err_early", timeout_err, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_err_set", timeout_err, 1'b1);
        chk("t6_still_waiting", req_out, 1'b1);
        ack_mode = 0;
        wait_idle("t6_idle_bound");
        chk("t6_err_sticky", timeout_err, 1'b1);
        chk("t6_rx", rx_cnt, tx_cnt);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_err_reset", timeout_err, 1'b0);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
